mis_stim_sequencer: RTL and testbench

- Sequences one multiple-input-switching (MIS) delay experiment on the two-input NOR measurement chain.
- Drives both chain inputs to a start level and lets them settle. Switches them to the opposite level with a programmable signed cycle skew, then times how long the chain output takes to reach its final level.
- Repeats the experiment N times and reports one cycle count per run.
- Sits between the lab control registers and the chain's two input pins and one output pin.

---
 rtl/mis_stim_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mis_stim_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mis_stim_sequencer.sv
// rtl/mis_stim_sequencer.sv - MIS skewed-switching delay sequencer for the two-input NOR chain
module mis_stim_sequencer #(
    parameter int SKEW_W  = 8,
    parameter int CNT_W   = 16,
    parameter int SETTLE  = 32,
    parameter int TIMEOUT = 4095
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     rise,
    input  logic signed [SKEW_W-1:0] skew,
    input  logic [7:0]               n_runs,
    input  logic                     chain_out,
    output logic                     drv_a1,
    output logic                     drv_a2,
    output logic                     busy,
    output logic                     meas_valid,
    output logic [CNT_W-1:0]         meas_cycles,
    output logic                     err_init,
    output logic                     err_timeout,
    output logic                     done
);
    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LEAD, S_MEAS, S_REPORT, S_DONE
    } state_t;

    state_t state, state_next;

    logic                     rise_q;
    logic signed [SKEW_W-1:0] skew_q;
    logic [7:0]               runs_q;
    logic [SET_W-1:0]         settle_cnt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cap_cnt;
    logic                     hit;
    logic                     sync1;
    logic                     out_s;

    logic                     skew_neg;
    logic                     skew_zero;
    logic [SKEW_W:0]          skew_abs;
    logic [CNT_W-1:0]         lag_last;
    logic                     at_target;
    logic                     settle_done;
    logic                     timeout_hit;

    // Extra bit lets the most negative skew produce a positive magnitude.
    assign skew_neg    = skew_q[SKEW_W-1];
    assign skew_zero   = (skew_q == '0);
    assign skew_abs    = skew_neg ? -{skew_q[SKEW_W-1], skew_q} : {1'b0, skew_q};
    assign lag_last    = CNT_W'(skew_abs) - CNT_W'(1);
    assign at_target   = (out_s == rise_q);
    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

    assign busy       = (state != S_IDLE);
    assign meas_valid = (state == S_REPORT);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_INIT;
            S_INIT: begin
                if (settle_done) begin
                    if (out_s == rise_q) state_next = S_REPORT;
                    else if (skew_zero)  state_next = S_MEAS;
                    else                 state_next = S_LEAD;
                end
            end
            S_LEAD:   if (cnt == lag_last) state_next = S_MEAS;
            S_MEAS:   if (hit || at_target || timeout_hit) state_next = S_REPORT;
            S_REPORT: state_next = (runs_q == 8'd1) ? S_DONE : S_INIT;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            out_s       <= 1'b0;
            rise_q      <= 1'b0;
            skew_q      <= '0;
            runs_q      <= 8'd0;
            settle_cnt  <= '0;
            cnt         <= '0;
            cap_cnt     <= '0;
            hit         <= 1'b0;
            drv_a1      <= 1'b0;
            drv_a2      <= 1'b0;
            meas_cycles <= '0;
            err_init    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            sync1 <= chain_out;
            out_s <= sync1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rise_q      <= rise;
                        skew_q      <= skew;
                        runs_q      <= (n_runs == 8'd0) ? 8'd1 : n_runs;
                        err_init    <= 1'b0;
                        err_timeout <= 1'b0;
                        drv_a1      <= ~rise;
                        drv_a2      <= ~rise;
                        settle_cnt  <= '0;
                    end
                end
                S_INIT: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    cnt        <= '0;
                    hit        <= 1'b0;
                    if (settle_done) begin
                        if (out_s == rise_q) begin
                            err_init    <= 1'b1;
                            meas_cycles <= '0;
                        end else begin
                            if (skew_zero || !skew_neg) drv_a1 <= rise_q;
                            if (skew_zero || skew_neg)  drv_a2 <= rise_q;
                        end
                    end
                end
                S_LEAD: begin
                    // A rising output can arrive before the lagging edge; remember the first hit.
                    cnt <= cnt + CNT_W'(1);
                    if (at_target && !hit) begin
                        hit     <= 1'b1;
                        cap_cnt <= cnt;
                    end
                    if (cnt == lag_last) begin
                        if (skew_neg) drv_a1 <= rise_q;
                        else          drv_a2 <= rise_q;
                    end
                end
                S_MEAS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (hit) begin
                        meas_cycles <= cap_cnt;
                    end else if (at_target) begin
                        meas_cycles <= cnt;
                    end else if (timeout_hit) begin
                        meas_cycles <= CNT_W'(TIMEOUT);
                        err_timeout <= 1'b1;
                    end
                end
                S_REPORT: begin
                    runs_q <= runs_q - 8'd1;
                    if (runs_q != 8'd1) begin
                        drv_a1     <= ~rise_q;
                        drv_a2     <= ~rise_q;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mis_stim_sequencer.sv
// tb/tb_mis_stim_sequencer.sv - randomized self-checking bench for mis_stim_sequencer
module tb_mis_stim_sequencer;
    localparam int TIMEOUT = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rise_in = 1'b0;
    logic [7:0]  skew_in = 8'd0;
    logic [7:0]  n_runs_in = 8'd0;
    logic        chain_out = 1'b0;
    logic        drv_a1, drv_a2, busy, meas_valid, err_init, err_timeout, done;
    logic [15:0] meas_cycles;

    int checks = 0;
    int failures = 0;

    logic [63:0] hist = '0;
    int          model_delay = 5;
    bit          model_stuck = 1'b0;

    mis_stim_sequencer #(.SKEW_W(8), .CNT_W(16), .SETTLE(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rise(rise_in), .skew(skew_in),
        .n_runs(n_runs_in), .chain_out(chain_out), .drv_a1(drv_a1), .drv_a2(drv_a2),
        .busy(busy), .meas_valid(meas_valid), .meas_cycles(meas_cycles),
        .err_init(err_init), .err_timeout(err_timeout), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Chain model: output follows A1|A2 (NOR plus output inverter) d cycles later, or stuck at 0.
    task automatic wait_cycle();
        @(negedge clk);
        hist = {hist[62:0], drv_a1 | drv_a2};
        chain_out = model_stuck ? 1'b0 : hist[model_delay];
    endtask

    function automatic int exp_cycles(input bit r, input int sk, input int d);
        int t;
        t = r ? d + 2 : ((sk < 0) ? -sk : sk) + d + 2;
        return (t > TIMEOUT) ? TIMEOUT : t;
    endfunction

    task automatic run_batch(input bit r, input int sk, input int n, input int d,
                             input bit stk, input bit poke);
        int  runs, pulses, t1, t2, ec;
        bit  exp_init, exp_to, fin, p1, p2;
        runs     = (n == 0) ? 1 : n;
        exp_init = stk && !r;
        exp_to   = stk && r;
        ec       = exp_init ? 0 : (exp_to ? TIMEOUT : exp_cycles(r, sk, d));
        model_delay = d;
        model_stuck = stk;
        start = 1'b1; rise_in = r; skew_in = 8'(sk); n_runs_in = 8'(n);
        wait_cycle();
        start = 1'b0; rise_in = 1'($urandom); skew_in = 8'($urandom); n_runs_in = 8'($urandom);
        p1 = drv_a1; p2 = drv_a2; t1 = -1; t2 = -1; pulses = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            wait_cycle();
            if (poke && cyc == 40) begin
                start = 1'b1; rise_in = ~r; n_runs_in = 8'd5; skew_in = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (drv_a1 != p1 && drv_a1 == r) t1 = cyc;
            if (drv_a2 != p2 && drv_a2 == r) t2 = cyc;
            p1 = drv_a1; p2 = drv_a2;
            if (meas_valid) begin
                check("meas_cycles", meas_cycles, ec);
                if (!exp_init) check("skew_edges", t2 - t1, sk);
                pulses++; t1 = -1; t2 = -1;
            end
            if (done) begin
                fin = 1'b1;
                check("err_init", err_init, exp_init);
                check("err_timeout", err_timeout, exp_to);
                check("pulse_count", pulses, runs);
                check("busy_at_done", busy, 1);
            end
        end
        if (!fin) check("batch_bound", 0, 1);
        wait_cycle();
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int  sk, d, n;
        bit  r, stk, seen;
        rst_n = 1'b0;
        repeat (3) wait_cycle();
        check("rst_drv_a1", drv_a1, 0);
        check("rst_drv_a2", drv_a2, 0);
        check("rst_busy", busy, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_done", done, 0);
        check("rst_meas_cycles", meas_cycles, 0);
        check("rst_errs", {err_init, err_timeout}, 0);
        rst_n = 1'b1;
        wait_cycle();

        run_batch(1, 0, 1, 5, 0, 0);
        run_batch(0, 10, 1, 5, 0, 0);
        run_batch(1, -4, 3, 3, 0, 0);
        run_batch(1, 7, 1, 4, 1, 0);
        run_batch(0, 2, 1, 4, 1, 0);
        run_batch(1, -128, 1, 2, 0, 0);
        run_batch(0, -128, 2, 6, 0, 0);
        run_batch(0, 127, 1, 3, 0, 0);
        run_batch(1, 0, 0, 8, 0, 0);
        run_batch(1, 3, 2, 6, 0, 1);

        // Reset in the middle of a measurement, then a clean batch.
        model_delay = 9; model_stuck = 1'b0;
        start = 1'b1; rise_in = 1'b1; skew_in = 8'd0; n_runs_in = 8'd2;
        wait_cycle();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            wait_cycle();
            if (i == 10) start = 1'b1; else start = 1'b0;
            seen = drv_a1;
        end
        check("reach_meas", seen, 1);
        wait_cycle();
        wait_cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_drv_a1", drv_a1, 0);
        check("midrst_drv_a2", drv_a2, 0);
        check("midrst_busy", busy, 0);
        check("midrst_meas_valid", meas_valid, 0);
        wait_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_cycle();
            check("post_rst_quiet", {busy, meas_valid, done}, 0);
        end
        run_batch(1, 5, 1, 7, 0, 0);

        for (int k = 0; k < 14; k++) begin
            r   = 1'($urandom);
            sk  = int'($urandom_range(0, 255)) - 128;
            d   = int'($urandom_range(1, 20));
            stk = ($urandom_range(0, 7) == 0);
            n   = stk ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            run_batch(r, sk, n, d, stk, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
